control_sequencer: RTL
======================

Name: control_sequencer

Overview:
- Downstream consumer of the instruction register's opcode nibble.
- Runs the fetch/execute T-state ring, T1..T6, and decodes opcode × T-state into the 12-bit control word.
- The control word drives the program counter, MAR, RAM, instruction register, accumulator A, register B, ALU and output register.
- Also generates the machine halt.

Parameters:
- OP_LDA, 4'b0000, load A from memory[address]
- OP_ADD, 4'b0001, A <= A + memory[address]
- OP_SUB, 4'b0010, A <= A - memory[address]
- OP_OUT, 4'b1110, output register <= A
- OP_HLT, 4'b1111, stop the machine

Ports:
- clk  input  1  system clock, all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- run  input  1  high = sequencer advances; low = frozen (pause/single-step gating)
- opcode  input  4  opcode from the instruction register, valid from T4 onward
- ctrl  output  12  control word, active-high; bit map: [11]Cp PC increment, [10]Ep PC out, [9]Lm MAR load, [8]Ce RAM out, [7]Ii IR load, [6]Io IR address out, [5]La A load, [4]Ea A out, [3]Su ALU subtract, [2]Eu ALU out, [1]Lb B load, [0]Lo output-register load
- halt  output  1  high once HLT has executed; held until reset
- t_state  output  6  one-hot current T-state, bit0 = T1; for debug and display

Behaviour:
- State: 6-bit one-hot ring (T1..T6) plus a halted flag. The ring is registered.
- ctrl is combinational from ring, opcode, run, halt and rst.
- Reset (rst high at a rising edge): ring <= T1 (t_state = 6'b000001), halt <= 0.
- While rst is high, ctrl is forced to 0. Reset mid-instruction abandons the instruction; the next cycle starts fetch at T1.
- Advance: on each rising edge with rst=0, run=1, halt=0, ring rotates T1->T2->...->T6->T1.
- When run=0: ring holds and ctrl is forced to 0, so no register is loaded or incremented twice. Resuming continues from the held T-state.
- Fetch, opcode-independent:
  - T1: Ep, Lm
  - T2: Cp
  - T3: Ce, Ii
- The IR loads at the end of T3, so opcode is sampled only in T4..T6.
- LDA:
  - T4: Io, Lm
  - T5: Ce, La
  - T6: none
- ADD:
  - T4: Io, Lm
  - T5: Ce, Lb
  - T6: Eu, La
- SUB: same as ADD, with Su also asserted in T5 and T6 so the ALU result is settled before La.
- OUT:
  - T4: Ea, Lo
  - T5, T6: none
- HLT:
  - T4: ctrl = 0; at the T4 rising edge, halt <= 1 and the ring freezes at T4.
  - While halt=1: ctrl = 0 regardless of run or opcode; only rst clears it.
- Undefined opcodes: ctrl = 0 in T4..T6 (NOP). The ring still completes to T1.
- Latency: every instruction takes exactly 6 clocks with run held high (HLT excepted).
- Precedence when events coincide: rst > halt > run.
- No bit of ctrl other than those listed above is ever asserted. Bus contention is prevented by construction: at most one of Ep, Ce, Io, Ea, Eu per T-state.

Decomposition:
- Shared package (cpu_pkg) holds:
  - opcode constants
  - T-state index constants
  - ctrl bit-position constants (CTRL_CP..CTRL_LO), also used by the datapath top level
- One sub-module, ring_counter6: 6-bit one-hot rotator with sync reset to 6'b000001 and an enable.
- The decode logic stays in control_sequencer.

Test Plan:
- Reset: rst=1 for 2 clocks -> t_state=000001, ctrl=0, halt=0. Release -> ctrl=12'h600 (Ep|Lm) in T1, 12'h800 (Cp) in T2, 12'h180 (Ce|Ii) in T3.
- LDA (opcode 0000) from T4 -> ctrl 12'h240 (Io|Lm), then 12'h120 (Ce|La), then 12'h000; t_state returns to 000001 on clock 7.
- ADD vs SUB over T4..T6:
  - ADD -> 12'h240, 12'h102, 12'h024
  - SUB -> 12'h240, 12'h10A, 12'h02C
- OUT then HLT:
  - OUT -> T4 ctrl=12'h011.
  - HLT -> halt=1 after the T4 edge, ctrl=0 and t_state=001000 held for 20 clocks even with run toggled.
  - rst=1 -> halt=0, t_state=000001.
- Pause: drop run in T2 for 5 clocks -> t_state stays 000010, ctrl=0. Raise run -> ctrl=12'h800 for one clock, then T3.
- Reset mid-execute: assert rst during T5 of ADD -> next cycle t_state=000001, ctrl=0 while rst=1, fetch restarts cleanly. Undefined opcode 0101 -> ctrl=0 in T4..T6.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode, T-state index and control-bit position constants
package cpu_pkg;
  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;
  localparam int T1 = 0;
  localparam int T2 = 1;
  localparam int T3 = 2;
  localparam int T4 = 3;
  localparam int T5 = 4;
  localparam int T6 = 5;
  localparam int CTRL_CP = 11;
  localparam int CTRL_EP = 10;
  localparam int CTRL_LM = 9;
  localparam int CTRL_CE = 8;
  localparam int CTRL_II = 7;
  localparam int CTRL_IO = 6;
  localparam int CTRL_LA = 5;
  localparam int CTRL_EA = 4;
  localparam int CTRL_SU = 3;
  localparam int CTRL_EU = 2;
  localparam int CTRL_LB = 1;
  localparam int CTRL_LO = 0;
endpackage

// File: rtl/ring_counter6.sv
// ring_counter6: 6-bit one-hot rotator; ports clk, rst (sync, to 000001), en (rotate), ring (one-hot state)
module ring_counter6 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [5:0] ring
);
  logic [5:0] ring_d, ring_q;
  always_comb ring_d = rst ? 6'b000001 : en ? {ring_q[4:0], ring_q[5]} : ring_q;
  always_ff @(posedge clk) ring_q <= ring_d;
  assign ring = ring_q;
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: T1..T6 ring plus opcode decode into the 12-bit control word and halt; ports clk, rst, run, opcode in; ctrl, halt, t_state out
module control_sequencer
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [3:0]  opcode,
  output logic [11:0] ctrl,
  output logic        halt,
  output logic [5:0]  t_state
);
  logic [5:0] t;
  logic halt_d, halt_q, act, hlt_now, lda, add, sub, out, mem, alu;
  assign lda = opcode == OP_LDA;
  assign add = opcode == OP_ADD;
  assign sub = opcode == OP_SUB;
  assign out = opcode == OP_OUT;
  assign mem = lda | add | sub;
  assign alu = add | sub;
  assign act = !rst && !halt_q && run;
  // HLT is taken at the T4 edge and freezes the ring there
  assign hlt_now = act && t[T4] && opcode == OP_HLT;
  ring_counter6 u_ring (.clk(clk), .rst(rst), .en(act && !hlt_now), .ring(t));
  always_comb halt_d = rst ? 1'b0 : halt_q | hlt_now;
  always_ff @(posedge clk) halt_q <= halt_d;
  always_comb begin
    ctrl = '0;
    ctrl[CTRL_CP] = t[T2];
    ctrl[CTRL_EP] = t[T1];
    ctrl[CTRL_LM] = t[T1] | (t[T4] & mem);
    ctrl[CTRL_CE] = t[T3] | (t[T5] & mem);
    ctrl[CTRL_II] = t[T3];
    ctrl[CTRL_IO] = t[T4] & mem;
    ctrl[CTRL_LA] = (t[T5] & lda) | (t[T6] & alu);
    ctrl[CTRL_EA] = t[T4] & out;
    ctrl[CTRL_SU] = (t[T5] | t[T6]) & sub;
    ctrl[CTRL_EU] = t[T6] & alu;
    ctrl[CTRL_LB] = t[T5] & alu;
    ctrl[CTRL_LO] = t[T4] & out;
    ctrl = act ? ctrl : '0;
  end
  assign halt = halt_q;
  assign t_state = t;
endmodule
